// File: rtl/bus_pkg.sv
// Shared types and sizes for the two-master system bus arbiter.
package bus_pkg;

  typedef logic master_id_t;

  localparam int unsigned NUM_MASTERS            = 2;
  localparam int unsigned DEFAULT_TAG_FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W                 = 30;
  localparam int unsigned DATA_W                 = 32;
  localparam int unsigned BE_W                   = 4;

endpackage

// File: rtl/tag_fifo.sv
// Tag FIFO recording which master owns each outstanding read, in issue order.
module tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot being written, so push is allowed while full then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// Two-master system bus arbiter with round-robin on contention and in-order read return routing.
module system_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TAG_FIFO_DEPTH = DEFAULT_TAG_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,

  output logic        m0_ready,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,

  output logic        m1_ready,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,

  input  logic        system_bus_ready,
  output logic [29:0] system_bus_addr,
  output logic [31:0] system_bus_write_data,
  output logic [3:0]  system_bus_byte_enable,
  output logic        system_bus_write_req,
  output logic        system_bus_read_req,
  input  logic [31:0] system_bus_read_data,
  input  logic        system_bus_read_data_valid,

  output logic        error
);

  logic [NUM_MASTERS-1:0] rd;
  logic [NUM_MASTERS-1:0] wr;
  logic [NUM_MASTERS-1:0] want;
  logic                   fifo_full;
  logic                   fifo_empty;
  master_id_t             fifo_head;
  logic                   pop_fire;
  logic                   room;
  logic                   grant_valid;
  master_id_t             winner;
  master_id_t             prio;
  logic                   accept;
  logic                   push;

  assign rd = {m1_read_req,  m0_read_req};
  assign wr = {m1_write_req, m0_write_req};

  assign pop_fire = reset_n && system_bus_read_data_valid && !fifo_empty;
  assign room     = !fifo_full || pop_fire;
  // Reads are masked while no tag slot is available; writes always compete.
  assign want     = reset_n ? (wr | (rd & {NUM_MASTERS{room}})) : '0;

  always_comb begin
    grant_valid = |want;
    winner      = 1'b0;
    if (&want) winner = prio;
    else       winner = want[1];
  end

  // Route the winner onto the bus; idle bus is all zeros.
  always_comb begin
    system_bus_addr        = '0;
    system_bus_write_data  = '0;
    system_bus_byte_enable = '0;
    system_bus_write_req   = 1'b0;
    system_bus_read_req    = 1'b0;
    if (grant_valid) begin
      system_bus_addr        = winner ? m1_addr        : m0_addr;
      system_bus_write_data  = winner ? m1_write_data  : m0_write_data;
      system_bus_byte_enable = winner ? m1_byte_enable : m0_byte_enable;
      system_bus_write_req   = wr[winner];
      system_bus_read_req    = rd[winner] && !wr[winner];
    end
  end

  assign accept   = grant_valid && system_bus_ready;
  assign m0_ready = accept && (winner == 1'b0);
  assign m1_ready = accept && (winner == 1'b1);
  assign push     = accept && system_bus_read_req;

  assign m0_read_data       = system_bus_read_data;
  assign m1_read_data       = system_bus_read_data;
  assign m0_read_data_valid = pop_fire && (fifo_head == 1'b0);
  assign m1_read_data_valid = pop_fire && (fifo_head == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio  <= 1'b0;
      error <= 1'b0;
    end else begin
      if (accept && (&want)) prio <= ~winner;
      if (system_bus_read_data_valid && fifo_empty) error <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (winner),
    .pop       (pop_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
